// File: rtl/spi_flash_apb_arb.sv
// Two-master APB arbiter in front of the SPI flash slave: m0 is the read-only fetch path and m1 is the data path.
// Define SPI_FLASH_ARB_FETCH_PRIO_EN for fixed m0 priority; leave it undefined for round-robin.
module spi_flash_apb_arb #(
  parameter int P_ADDR_W      = 32,
  parameter int P_DATA_W      = 32,
  parameter int P_STRB_W      = 4,
  parameter bit RR_RESET_LAST = 1'b1
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [P_ADDR_W-1:0] m0_paddr,
  input  logic [P_DATA_W-1:0] m0_pwdata,
  input  logic [P_STRB_W-1:0] m0_pwstrb,
  output logic                m0_pready,
  output logic                m0_pslverr,
  output logic [P_DATA_W-1:0] m0_prdata,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [P_ADDR_W-1:0] m1_paddr,
  input  logic [P_DATA_W-1:0] m1_pwdata,
  input  logic [P_STRB_W-1:0] m1_pwstrb,
  output logic                m1_pready,
  output logic                m1_pslverr,
  output logic [P_DATA_W-1:0] m1_prdata,
  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [P_ADDR_W-1:0] s_paddr,
  output logic [P_DATA_W-1:0] s_pwdata,
  output logic [P_STRB_W-1:0] s_pwstrb,
  input  logic                s_pready,
  input  logic                s_pslverr,
  input  logic [P_DATA_W-1:0] s_prdata
);

  // state  | meaning
  // IDLE   | sampling requests, no downstream activity
  // SETUP  | downstream setup phase (psel=1, penable=0), one cycle
  // ACCESS | downstream access phase, held until s_pready
  // ERR    | m0 attempted a write; error response to m0 for one cycle
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                gnt_sel;
  logic                pwrite_q, pwrite_d;
  logic [P_ADDR_W-1:0] paddr_q, paddr_d;
  logic [P_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [P_STRB_W-1:0] pwstrb_q, pwstrb_d;
  logic                req0, req1;
  logic                done, err;
`ifndef SPI_FLASH_ARB_FETCH_PRIO_EN
  logic                last_q, last_d;
`endif

  assign req0 = m0_psel && m0_penable;
  assign req1 = m1_psel && m1_penable;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwstrb_d = pwstrb_q;
`ifdef SPI_FLASH_ARB_FETCH_PRIO_EN
    gnt_sel  = !req0;
`else
    last_d   = last_q;
    gnt_sel  = (req0 && req1) ? !last_q : req1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d    = gnt_sel;
`ifndef SPI_FLASH_ARB_FETCH_PRIO_EN
          last_d   = gnt_sel;
`endif
          pwrite_d = gnt_sel ? m1_pwrite : m0_pwrite;
          paddr_d  = gnt_sel ? m1_paddr  : m0_paddr;
          pwdata_d = gnt_sel ? m1_pwdata : m0_pwdata;
          pwstrb_d = gnt_sel ? m1_pwstrb : m0_pwstrb;
          // the fetch path is read-only, so its writes never reach the flash
          state_d  = (!gnt_sel && m0_pwrite) ? ST_ERR : ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (s_pready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwstrb_q <= '0;
`ifndef SPI_FLASH_ARB_FETCH_PRIO_EN
      last_q   <= RR_RESET_LAST;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwstrb_q <= pwstrb_d;
`ifndef SPI_FLASH_ARB_FETCH_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign s_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign s_penable = (state_q == ST_ACCESS);
  assign s_pwrite  = pwrite_q;
  assign s_paddr   = paddr_q;
  assign s_pwdata  = pwdata_q;
  assign s_pwstrb  = pwstrb_q;

  assign done = (state_q == ST_ACCESS) && s_pready;
  assign err  = (state_q == ST_ERR);

  assign m0_pready  = (done && !gnt_q) || err;
  assign m0_pslverr = (done && !gnt_q && s_pslverr) || err;
  assign m0_prdata  = (done && !gnt_q) ? s_prdata : '0;
  assign m1_pready  = done && gnt_q;
  assign m1_pslverr = done && gnt_q && s_pslverr;
  assign m1_prdata  = (done && gnt_q) ? s_prdata : '0;

endmodule

// File: tb/tb_spi_flash_apb_arb.sv
// Bench for spi_flash_apb_arb: the bench plays both masters and the flash slave, and checks the arbiter against a transaction-timing reference model.
module tb_spi_flash_apb_arb;

  logic        pclk = 1'b0;
  logic        preset;
  logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
  logic [3:0]  m0_pwstrb;
  logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
  logic [3:0]  m1_pwstrb;
  logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic [3:0]  s_pwstrb;

  always #5 pclk = ~pclk;

  spi_flash_apb_arb dut (
    .pclk(pclk), .preset(preset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata)
  );

  // a transaction carries the slave's response and timing along with the request
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        write;
    logic [31:0] rdata;
    logic        slverr;
    int          wt;
    int          gap;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;
  txn_t q0[$];
  txn_t q1[$];
  int ph[2];
  int gapc[2];
  int owner = -1;
  int g_cyc = 0;
  bit err_g = 1'b0;
  int free_at = 0;
  int cyc = 0;
  int rr_last = 1;
  txn_t cur;
  int done_log[$];
  logic [31:0] ex_addr, ex_wdata;
  logic [3:0]  ex_strb;
  logic        ex_write;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                              input logic wr, input logic [31:0] rd, input logic se,
                              input int wt, input int gap);
    txn_t t;
    t.addr = a; t.wdata = wd; t.strb = st; t.write = wr;
    t.rdata = rd; t.slverr = se; t.wt = wt; t.gap = gap;
    return t;
  endfunction

  task automatic drive_m();
    txn_t h0, h1;
    h0 = mk(0, 0, 0, 0, 0, 0, 0, 0);
    h1 = h0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    m0_psel = (ph[0] >= 1); m0_penable = (ph[0] == 2);
    m0_pwrite = h0.write; m0_paddr = h0.addr; m0_pwdata = h0.wdata; m0_pwstrb = h0.strb;
    m1_psel = (ph[1] >= 1); m1_penable = (ph[1] == 2);
    m1_pwrite = h1.write; m1_paddr = h1.addr; m1_pwdata = h1.wdata; m1_pwstrb = h1.strb;
  endtask

  task automatic push0(input txn_t t);
    if (q0.size() == 0) gapc[0] = t.gap;
    q0.push_back(t);
  endtask

  task automatic push1(input txn_t t);
    if (q1.size() == 0) gapc[1] = t.gap;
    q1.push_back(t);
  endtask

  // one bus cycle: arbitrate in the model, act as slave, check, then advance masters
  task automatic step();
    bit r0, r1, upd, in_acc, comp, e_psel, e_pen, e_rdy0, e_rdy1;
    int w, comp_cyc;
    upd = 1'b0;
    r0 = (ph[0] == 2);
    r1 = (ph[1] == 2);
    if (owner < 0 && cyc >= free_at && (r0 || r1)) begin
`ifdef SPI_FLASH_ARB_FETCH_PRIO_EN
      w = r0 ? 0 : 1;
`else
      w = (r0 && r1) ? 1 - rr_last : (r0 ? 0 : 1);
`endif
      rr_last = w;
      owner = w;
      g_cyc = cyc;
      cur = (w == 0) ? q0[0] : q1[0];
      err_g = (w == 0) && cur.write;
      upd = 1'b1;
    end
    comp_cyc = err_g ? g_cyc + 1 : g_cyc + 2 + cur.wt;
    in_acc = (owner >= 0) && !err_g && (cyc >= g_cyc + 2);
    comp = (owner >= 0) && (cyc == comp_cyc);
    if (in_acc) begin
      s_pready  = comp;
      s_prdata  = comp ? cur.rdata : $urandom;
      s_pslverr = comp ? cur.slverr : 1'($urandom);
    end else begin
      s_pready  = 1'($urandom);
      s_prdata  = $urandom;
      s_pslverr = 1'($urandom);
    end
    @(negedge pclk);
    e_psel = (owner >= 0) && !err_g && (cyc >= g_cyc + 1);
    e_pen  = e_psel && (cyc >= g_cyc + 2);
    e_rdy0 = comp && (owner == 0);
    e_rdy1 = comp && (owner == 1);
    chk("s_psel", s_psel, e_psel);
    chk("s_penable", s_penable, e_pen);
    chk("s_paddr", s_paddr, ex_addr);
    chk("s_pwdata", s_pwdata, ex_wdata);
    chk("s_pwstrb", s_pwstrb, ex_strb);
    chk("s_pwrite", s_pwrite, ex_write);
    chk("m0_pready", m0_pready, e_rdy0);
    chk("m0_pslverr", m0_pslverr, e_rdy0 && (err_g || cur.slverr));
    chk("m0_prdata", m0_prdata, (e_rdy0 && !err_g) ? cur.rdata : 32'h0);
    chk("m1_pready", m1_pready, e_rdy1);
    chk("m1_pslverr", m1_pslverr, e_rdy1 && cur.slverr);
    chk("m1_prdata", m1_prdata, e_rdy1 ? cur.rdata : 32'h0);
    if (m0_pready) done_log.push_back(0);
    if (m1_pready) done_log.push_back(1);
    if (upd) begin
      ex_addr = cur.addr; ex_wdata = cur.wdata; ex_strb = cur.strb; ex_write = cur.write;
    end
    for (int i = 0; i < 2; i++) begin
      if (ph[i] == 0) begin
        if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
          if (gapc[i] == 0) ph[i] = 1;
          else gapc[i]--;
        end
      end else if (ph[i] == 1) ph[i] = 2;
    end
    if (comp) begin
      if (owner == 0) begin
        void'(q0.pop_front());
        gapc[0] = (q0.size() > 0) ? q0[0].gap : 0;
      end else begin
        void'(q1.pop_front());
        gapc[1] = (q1.size() > 0) ? q1[0].gap : 0;
      end
      ph[owner] = 0;
      owner = -1;
      free_at = cyc + 1;
    end
    @(posedge pclk);
    #1;
    cyc++;
    drive_m();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    q0.delete(); q1.delete();
    ph[0] = 0; ph[1] = 0;
    owner = -1;
    err_g = 1'b0;
    drive_m();
    s_pready = 1'b1; s_pslverr = 1'b1; s_prdata = $urandom;
    @(posedge pclk);
    #1;
    @(negedge pclk);
    chk("rst_s_psel", s_psel, 0);
    chk("rst_s_penable", s_penable, 0);
    chk("rst_s_pwrite", s_pwrite, 0);
    chk("rst_s_paddr", s_paddr, 0);
    chk("rst_s_pwdata", s_pwdata, 0);
    chk("rst_s_pwstrb", s_pwstrb, 0);
    chk("rst_m0_pready", m0_pready, 0);
    chk("rst_m0_pslverr", m0_pslverr, 0);
    chk("rst_m0_prdata", m0_prdata, 0);
    chk("rst_m1_pready", m1_pready, 0);
    chk("rst_m1_pslverr", m1_pslverr, 0);
    chk("rst_m1_prdata", m1_prdata, 0);
    @(posedge pclk);
    #1;
    preset = 1'b0;
    cyc = 0; free_at = 0; rr_last = 1;
    ex_addr = 0; ex_wdata = 0; ex_strb = 0; ex_write = 0;
    drive_m();
  endtask

  task automatic chk_order(input string tag, input int exp[$]);
    chk({tag, "_len"}, done_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < done_log.size(); i++)
      chk(tag, done_log[i], exp[i]);
    done_log.delete();
  endtask

  initial begin
    int exp_ord[$];
    txn_t t;
    preset = 1'b1;
    s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = 0;
    ph[0] = 0; ph[1] = 0; gapc[0] = 0; gapc[1] = 0;
    drive_m();
    do_reset();

    // single m1 read, slave answers in the fifth ACCESS cycle
    push1(mk(32'h4000_0010, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001, 1'b0, 4, 0));
    run_until_empty(100);
    exp_ord = '{1};
    chk_order("single_m1", exp_ord);

    // simultaneous pairs around a lone m0 access
    do_reset();
    push0(mk(32'h4000_0100, 0, 4'hF, 1'b0, 32'h1111_0000, 1'b0, 2, 0));
    push1(mk(32'h4000_0200, 0, 4'hF, 1'b0, 32'h2222_0000, 1'b0, 1, 0));
    run_until_empty(100);
    push0(mk(32'h4000_0104, 0, 4'hF, 1'b0, 32'h1111_0001, 1'b0, 0, 0));
    run_until_empty(100);
    push0(mk(32'h4000_0108, 0, 4'hF, 1'b0, 32'h1111_0002, 1'b0, 3, 1));
    push1(mk(32'h4000_0208, 0, 4'hF, 1'b0, 32'h2222_0002, 1'b0, 0, 1));
    run_until_empty(100);
`ifdef SPI_FLASH_ARB_FETCH_PRIO_EN
    exp_ord = '{0, 1, 0, 0, 1};
`else
    exp_ord = '{0, 1, 0, 1, 0};
`endif
    chk_order("pair_order", exp_ord);

    // m0 write is refused without touching the flash
    push0(mk(32'h4000_0000, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'h0, 1'b0, 0, 0));
    run_until_empty(50);
    exp_ord = '{0};
    chk_order("m0_write_err", exp_ord);

    // slave error on an m1 write, then a normal m1 read
    push1(mk(32'h4000_0010, 32'h0000_00C3, 4'h1, 1'b1, 32'h0, 1'b1, 2, 0));
    push1(mk(32'h4000_0014, 32'h0, 4'hF, 1'b0, 32'h7777_8888, 1'b0, 1, 1));
    run_until_empty(100);
    exp_ord = '{1, 1};
    chk_order("m1_slverr", exp_ord);

    // reset in the middle of ACCESS, then a fresh m0 read
    push1(mk(32'h4000_0020, 0, 4'hF, 1'b0, 32'h9999_0000, 1'b0, 10, 0));
    repeat (6) step();
    chk("mid_access_penable", s_penable, 1);
    do_reset();
    exp_ord = '{};
    chk_order("reset_drop", exp_ord);
    push0(mk(32'h4000_0030, 0, 4'hF, 1'b0, 32'h3030_3030, 1'b0, 2, 0));
    run_until_empty(100);
    exp_ord = '{0};
    chk_order("post_reset_m0", exp_ord);

    // randomized traffic on both ports
    do_reset();
    for (int i = 0; i < 120; i++) begin
      t = mk(32'h4000_0000 + (32'($urandom_range(0, 1023)) << 2), $urandom, 4'($urandom),
             ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 4) == 0),
             $urandom_range(0, 6), $urandom_range(0, 3));
      push0(t);
      t = mk(32'h4000_0000 + (32'($urandom_range(0, 1023)) << 2), $urandom, 4'($urandom),
             1'($urandom), $urandom, ($urandom_range(0, 4) == 0),
             $urandom_range(0, 6), $urandom_range(0, 3));
      push1(t);
    end
    run_until_empty(20000);
    chk("random_done_count", done_log.size(), 240);
    done_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
